// File: rtl/disp_scan_mux_pkg.sv
// Shared helpers and constants for the display scan multiplexer.
// Combinational only; no latency.
// No flow control; everything here is evaluated at elaboration or in logic.
package disp_scan_mux_pkg;

  // Widest channel count the one-hot helper can encode.
  localparam int MAX_CH = 32;

  // Slot length for simulation, and for a 50 MHz board (about 1 kHz per digit).
  localparam int DIV_SIM   = 3;
  localparam int DIV_BOARD = 50000;

  // Ceiling log2 with a floor of 1, so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Index to one-hot; callers truncate to their own channel count.
  function automatic logic [MAX_CH-1:0] onehot(input logic [31:0] pos);
    return MAX_CH'(1) << pos;
  endfunction

endpackage

// File: rtl/disp_scan_mux_prescaler.sv
// Slot prescaler: emits tick on the last cycle of each DIV-cycle slot.
// Latency: tick is combinational from the counter state.
// Backpressure: hold freezes the counter and suppresses tick.
module scan_prescaler
  import disp_scan_mux_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic tick
);

  localparam int            CW   = clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 LAST is zero and the counter sits at zero, ticking every cycle.
  assign tick = !hold && (cnt == LAST);

  // Slot counter: wraps on tick, frozen while held so the slot resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Display scan mux: shadows CH words and time-multiplexes them onto sel/out.
// Latency: sel/out are registered; a channel change appears at the tick edge.
// Backpressure: none; hold freezes the scan while out keeps refreshing.
module disp_scan_mux
  import disp_scan_mux_pkg::*;
#(
  parameter int             N     = 8,
  parameter int             CH    = 4,
  parameter int             DIV   = 50000,
  parameter logic [N-1:0]   BLANK = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*N-1:0] data_in,
  input  logic            load,
  input  logic [CH-1:0]   en,
  input  logic            hold,
  output logic [CH-1:0]   sel,
  output logic [N-1:0]    out,
  output logic            frame_done
);

  localparam int            IW       = clog2(CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(CH - 1);

  logic                  tick;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_next;
  logic [CH-1:0]         sel_next;
  logic [CH-1:0][N-1:0]  shadow;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .tick  (tick)
  );

  // Next scan position: advance on tick, wrapping explicitly so non-power-of-2 CH never overruns.
  always_comb begin
    idx_next = idx;
    sel_next = CH'(onehot(32'(idx)));
    if (tick) begin
      idx_next = (idx == LAST_IDX) ? '0 : idx + IW'(1);
    end
    sel_next = CH'(onehot(32'(idx_next)));
  end

  // Shadow buffer: all channels captured on the same edge so a frame is never mixed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (load) begin
      shadow <= data_in;
    end
  end

  // Scan index and output registers; sel and out both derive from idx_next so they stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      sel        <= CH'(1);
      out        <= '0;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_next;
      sel        <= sel_next;
      out        <= en[idx_next] ? shadow[idx_next] : BLANK;
      frame_done <= tick && (idx == LAST_IDX);
    end
  end

endmodule
